// File: rtl/sobel_edge_map_writer.sv
// Captures one frame of the 1-bit Sobel edge stream, packs it MSB-first into
// row-padded bytes, writes them to a byte-wide RAM and counts edge pixels.
module sobel_edge_map_writer #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int ADDR_W     = 13,
  parameter int CNT_W      = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              edge_in,
  input  logic              edge_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  edge_count,
  output logic [1:0]        dbg_state
);

  localparam int OUT_W  = IMG_WIDTH - 2;
  localparam int OUT_H  = IMG_HEIGHT - 2;
  localparam int BPR    = (OUT_W + 7) / 8;
  localparam int COL_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int ROW_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int BYTE_W = (BPR > 1) ? $clog2(BPR) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0] byte_idx_q, byte_idx_d;
  logic [7:0]        acc_q, acc_d;
  logic [CNT_W-1:0]  edge_count_q, edge_count_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              frame_done_q, frame_done_d;

  logic       last_col, last_row, byte_done;
  logic [7:0] acc_next;

  assign last_col  = (col_q == COL_W'(OUT_W - 1));
  assign last_row  = (row_q == ROW_W'(OUT_H - 1));
  assign byte_done = (bit_idx_q == 3'd7) || last_col;
  assign acc_next  = edge_in ? (acc_q | (8'h80 >> bit_idx_q)) : acc_q;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CAPTURE;
      S_CAPTURE: if (edge_valid && last_col && last_row) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state_q != S_IDLE);
    dbg_state = state_q;
  end

  // Datapath next-state; the write strobe is registered so it lands one
  // cycle after the valid that completes a byte.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    bit_idx_d    = bit_idx_q;
    byte_idx_d   = byte_idx_q;
    acc_d        = acc_q;
    edge_count_d = edge_count_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          col_d        = '0;
          row_d        = '0;
          bit_idx_d    = '0;
          byte_idx_d   = '0;
          acc_d        = '0;
          edge_count_d = '0;
        end
      end
      S_CAPTURE: begin
        if (edge_valid) begin
          if (edge_in && (edge_count_q != {CNT_W{1'b1}}))
            edge_count_d = edge_count_q + CNT_W'(1);
          if (byte_done) begin
            mem_we_d     = 1'b1;
            mem_addr_d   = ADDR_W'(32'(row_q) * 32'(BPR) + 32'(byte_idx_q));
            mem_wdata_d  = acc_next;
            acc_d        = '0;
            bit_idx_d    = '0;
            byte_idx_d   = last_col ? '0 : byte_idx_q + BYTE_W'(1);
            frame_done_d = last_col && last_row;
          end else begin
            acc_d     = acc_next;
            bit_idx_d = bit_idx_q + 3'd1;
          end
          if (last_col) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      bit_idx_q    <= '0;
      byte_idx_q   <= '0;
      acc_q        <= '0;
      edge_count_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      bit_idx_q    <= bit_idx_d;
      byte_idx_q   <= byte_idx_d;
      acc_q        <= acc_d;
      edge_count_q <= edge_count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign frame_done = frame_done_q;
  assign edge_count = edge_count_q;

endmodule

// File: tb/tb_sobel_edge_map_writer.sv
// Bench for sobel_edge_map_writer: directed frames on an 8x2 and a 10x1 output
// geometry, with writes matched against an expected-write queue.
module tb_sobel_edge_map_writer;

  localparam int AW = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic a_start = 1'b0, a_valid = 1'b0, a_edge = 1'b0;
  logic b_start = 1'b0, b_valid = 1'b0, b_edge = 1'b0;

  logic          a_we, a_busy, a_fd;
  logic [AW-1:0] a_addr;
  logic [7:0]    a_wdata;
  logic [16:0]   a_cnt;
  logic [1:0]    a_dbg;
  logic          b_we, b_busy, b_fd;
  logic [AW-1:0] b_addr;
  logic [7:0]    b_wdata;
  logic [16:0]   b_cnt;
  logic [1:0]    b_dbg;
  logic          c_we, c_busy, c_fd;
  logic [AW-1:0] c_addr;
  logic [7:0]    c_wdata;
  logic [2:0]    c_cnt;
  logic [1:0]    c_dbg;

  int errors = 0;
  int checks = 0;

  // Entry: {expected cycle[31:0], frame_done, addr[12:0], data[7:0]}
  logic [53:0] exp_a[$];
  logic [53:0] exp_b[$];

  sobel_edge_map_writer #(.IMG_WIDTH(10), .IMG_HEIGHT(4), .ADDR_W(AW), .CNT_W(17)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .edge_in(a_edge), .edge_valid(a_valid),
    .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata), .busy(a_busy),
    .frame_done(a_fd), .edge_count(a_cnt), .dbg_state(a_dbg));

  sobel_edge_map_writer #(.IMG_WIDTH(12), .IMG_HEIGHT(3), .ADDR_W(AW), .CNT_W(17)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .edge_in(b_edge), .edge_valid(b_valid),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .busy(b_busy),
    .frame_done(b_fd), .edge_count(b_cnt), .dbg_state(b_dbg));

  // Narrow counter copy of dut_b, used to observe saturation.
  sobel_edge_map_writer #(.IMG_WIDTH(12), .IMG_HEIGHT(3), .ADDR_W(AW), .CNT_W(3)) dut_c (
    .clk(clk), .rst(rst), .start(b_start), .edge_in(b_edge), .edge_valid(b_valid),
    .mem_we(c_we), .mem_addr(c_addr), .mem_wdata(c_wdata), .busy(c_busy),
    .frame_done(c_fd), .edge_count(c_cnt), .dbg_state(c_dbg));

  // Clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_we) begin
        if (exp_a.size() == 0) chk("a_unexpected_write", {cyc, a_addr, a_wdata}, 0);
        else chk("a_write", {32'(cyc), a_fd, a_addr, a_wdata}, exp_a.pop_front());
      end else if (a_fd) chk("a_done_without_write", a_fd, 0);
      if (b_we) begin
        if (exp_b.size() == 0) chk("b_unexpected_write", {cyc, b_addr, b_wdata}, 0);
        else chk("b_write", {32'(cyc), b_fd, b_addr, b_wdata}, exp_b.pop_front());
      end else if (b_fd) chk("b_done_without_write", b_fd, 0);
    end
  end

  // Driver tasks
  task automatic set_in(input bit sel, input logic st, input logic v, input logic e);
    if (!sel) begin a_start = st; a_valid = v; a_edge = e; end
    else      begin b_start = st; b_valid = v; b_edge = e; end
  endtask

  task automatic run_frame(input bit sel, input logic [31:0] frame, input int ow, input int oh,
                           input int bpr, input int exp_cnt, input int gap_max,
                           input int pre_junk, input int start_at);
    int npix;
    int r, c;
    logic [7:0]  acc;
    logic [53:0] ent;
    npix = ow * oh;
    for (int k = 0; k < pre_junk; k++) begin
      @(posedge clk); #1 set_in(sel, 1'b0, 1'b1, 1'b1);
    end
    @(posedge clk); #1 set_in(sel, 1'b1, 1'b1, 1'b1);
    acc = '0;
    for (int p = 0; p < npix; p++) begin
      @(posedge clk); #1 set_in(sel, p == start_at, 1'b1, frame[p]);
      r = p / ow;
      c = p % ow;
      if (frame[p]) acc[7 - (c % 8)] = 1'b1;
      if ((c % 8 == 7) || (c == ow - 1)) begin
        ent = {32'(cyc + 1), p == npix - 1, 13'(r * bpr + c / 8), acc};
        if (!sel) exp_a.push_back(ent);
        else      exp_b.push_back(ent);
        acc = '0;
      end
      if (p < npix - 1 && gap_max > 0) begin
        repeat ($urandom_range(gap_max, 1)) begin
          @(posedge clk); #1 set_in(sel, 1'b0, 1'b0, 1'($urandom_range(1, 0)));
        end
      end
    end
    @(posedge clk); #1 set_in(sel, 1'b0, 1'b1, 1'b1);
    chk("busy_in_done", sel ? b_busy : a_busy, 1);
    @(posedge clk); #1 set_in(sel, 1'b0, 1'b0, 1'b0);
    chk("busy_after_done", sel ? b_busy : a_busy, 0);
    chk("edge_count", sel ? b_cnt : a_cnt, exp_cnt);
    chk("writes_drained", sel ? exp_b.size() : exp_a.size(), 0);
    if (sel) chk("edge_count_saturated", c_cnt, (exp_cnt > 7) ? 7 : exp_cnt);
  endtask

  initial begin
    // Reset held two cycles with start high
    rst = 1'b1; a_start = 1'b1; b_start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", a_we, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_wdata", a_wdata, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_fd, 0);
    chk("rst_count", a_cnt, 0);
    chk("rst_busy_b", b_busy, 0);
    rst = 1'b0; a_start = 1'b0; b_start = 1'b0;
    repeat (2) @(posedge clk);

    // Back-to-back frame: 0xB0 then 0x01
    run_frame(1'b0, 32'h0000_800D, 8, 2, 1, 4, 0, 0, -1);
    // Ten ones on a 10-wide row: 0xFF then padded 0xC0
    run_frame(1'b1, 32'h0000_03FF, 10, 1, 2, 10, 0, 0, -1);
    // Same frame with idle gaps between valids
    run_frame(1'b0, 32'h0000_800D, 8, 2, 1, 4, 3, 0, -1);

    // Reset mid-frame after five valids: no partial write
    @(posedge clk); #1 set_in(1'b0, 1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      @(posedge clk); #1 set_in(1'b0, 1'b0, 1'b1, 1'b1);
    end
    @(posedge clk); #1 set_in(1'b0, 1'b0, 1'b0, 1'b0); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_busy", a_busy, 0);
    chk("midrst_count", a_cnt, 0);
    chk("midrst_we", a_we, 0);
    run_frame(1'b0, 32'h0000_800D, 8, 2, 1, 4, 0, 0, -1);

    // Junk valids before start, start re-pulsed mid-frame
    run_frame(1'b0, 32'h0000_800D, 8, 2, 1, 4, 2, 3, 5);
    repeat (3) @(posedge clk);
    #1 chk("idle_after_all", a_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sobel_edge_map_writer.md
Name: sobel_edge_map_writer

Overview:
Sink for the Sobel edge stream. Captures the 1-bit `sobel_out`/`valid` stream for one frame and packs it MSB-first into bytes, padding each output row to a whole number of bytes. Writes the bytes into a byte-wide edge-map RAM, counts edge pixels, and signals frame completion. Sits directly downstream of the Sobel edge detector, on the same clock.

Parameters:
- IMG_WIDTH, 256, input image width; output row width OUT_W = IMG_WIDTH-2.
- IMG_HEIGHT, 256, input image height; output row count OUT_H = IMG_HEIGHT-2.
- ADDR_W, 13, edge-map RAM byte-address width; must cover OUT_H*BPR, where BPR = ceil(OUT_W/8).
- CNT_W, 17, width of the edge pixel counter.

Ports:
- clk  in  1  Clock; all logic on the rising edge.
- rst  in  1  Reset; synchronous, active-high.
- start  in  1  Arms capture of one frame; honoured only in IDLE.
- edge_in  in  1  Edge bit (Sobel `sobel_out`).
- edge_valid  in  1  Qualifies `edge_in` (Sobel `valid`).
- mem_we  out  1  RAM write strobe, one cycle per byte.
- mem_addr  out  ADDR_W  RAM byte address.
- mem_wdata  out  8  Packed edge byte.
- busy  out  1  High while the FSM is not in IDLE.
- frame_done  out  1  One-cycle pulse, coincident with the final write.
- edge_count  out  CNT_W  Number of 1 bits captured in the frame; holds until the next accepted start.

Behaviour:
- Reset (synchronous): state=IDLE. mem_we, mem_addr, mem_wdata, busy, frame_done, edge_count all 0. Internal col, row, bit index and accumulator cleared. Reset mid-frame aborts the frame with no write of the partial byte.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - edge_valid ignored.
  - start=1 -> next cycle CAPTURE; col, row, bit index, accumulator, edge_count cleared.
  - A valid arriving in the same cycle as start is not captured.
- CAPTURE, on each cycle with edge_valid=1:
  - edge_in goes to accumulator bit (7 - bit_idx).
  - edge_count increments if edge_in=1.
  - col advances.
  - Gaps (edge_valid=0) are allowed; state is held during gaps.
- Byte completion: occurs when bit_idx==7 or col==OUT_W-1.
  - Next cycle: mem_we=1, mem_addr=row*BPR + byte_idx, mem_wdata = accumulator including the current bit, unused low bits 0.
  - Accumulator and bit_idx are cleared for the next byte.
  - Latency from the completing valid to mem_we: exactly 1 cycle.
  - mem_we is high for one cycle only; mem_addr and mem_wdata are don't-care when mem_we=0 but hold their last values.
- Row end (col==OUT_W-1): col<=0, byte_idx<=0, row<=row+1.
- Last pixel (row==OUT_H-1, col==OUT_W-1):
  - Next state DONE.
  - In DONE: final mem_we plus frame_done=1, busy=1.
  - Following cycle: IDLE, busy=0.
- start while busy is ignored; it does not restart the frame.
- edge_valid in DONE is ignored.
- Writes may occur on consecutive cycles; no backpressure exists and no bit may be dropped.
- edge_count saturates at all-ones (does not wrap).
- Address arithmetic is unsigned; the row*BPR product is computed at full width, then truncated to ADDR_W.

Test Plan:
1. Reset: assert rst for 2 cycles with start=1 -> all outputs 0, busy=0, no mem_we.
2. IMG_WIDTH=10, IMG_HEIGHT=4 (OUT_W=8, BPR=1): start, then feed bits 1,0,1,1,0,0,0,0 and 0,0,0,0,0,0,0,1 back-to-back.
   -> Write addr0=0xB0 one cycle after the 8th valid.
   -> Write addr1=0x01 with frame_done=1 in the same cycle.
   -> edge_count=4; busy drops the next cycle.
3. IMG_WIDTH=12, IMG_HEIGHT=3 (OUT_W=10, BPR=2): start, then 10 ones.
   -> Writes addr0=0xFF, then addr1=0xC0 with frame_done.
   -> edge_count=10.
4. Same as scenario 2, but with 1-3 idle cycles between valids -> identical writes and edge_count; no mem_we during gaps.
5. Reset mid-frame after 5 valids -> no write. Then start plus scenario 2 stimulus -> same result as scenario 2, edge_count=4 (no residue).
6. Valids before start, and start pulsed again mid-frame -> pre-start bits not written, frame unaffected, single frame_done.
